// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold-while-requesting ownership,
// a per-owner hold timeout and a block mask for masters that timed out.
module rr_arbiter_4 #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] gnt_idx,
   output logic       busy,
   output logic       timeout_err
);

   localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]    state, state_n;
   logic [1:0]    last, last_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    block, block_n;
   logic [1:0]    idx_n;
   logic          busy_n;
   logic          err_n;
   logic [3:0]    grant_n;
   logic [3:0]    eligible;
   logic [1:0]    pick;
   logic          found;

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last        <= 2'd3;
         cnt         <= '0;
         block       <= 4'b0000;
         gnt_idx     <= 2'd0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         grant       <= 4'b0000;
      end else begin
         state       <= state_n;
         last        <= last_n;
         cnt         <= cnt_n;
         block       <= block_n;
         gnt_idx     <= idx_n;
         busy        <= busy_n;
         timeout_err <= err_n;
         grant       <= grant_n;
      end
   end

   // Rotating priority scan starting just after the last owner
   always_comb begin
      logic [1:0] cand;
      eligible = req & ~block;
      found    = 1'b0;
      pick     = last;
      cand     = last;
      for (int i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and output decode
   always_comb begin
      state_n = state;
      last_n  = last;
      cnt_n   = cnt;
      idx_n   = gnt_idx;
      busy_n  = busy;
      err_n   = 1'b0;
      block_n = block & req;

      case (state)
         IDLE: begin
            if (found) begin
               state_n = GRANT;
               idx_n   = pick;
               busy_n  = 1'b1;
               cnt_n   = CW'(1);
            end
         end
         GRANT: begin
            if (!req[gnt_idx]) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               last_n  = gnt_idx;
            end else if ((TIMEOUT != 0) && (cnt >= CW'(TIMEOUT))) begin
               state_n          = IDLE;
               busy_n           = 1'b0;
               last_n           = gnt_idx;
               block_n[gnt_idx] = 1'b1;
               err_n            = 1'b1;
            end else if (cnt != {CW{1'b1}}) begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase

      grant_n = busy_n ? (4'b0001 << idx_n) : 4'b0000;
   end

endmodule
